// File: rtl/seg_disp_pkg.sv
// Shared constants, FSM encoding and glyph encoder for the segment scan display.
package seg_disp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLAMP  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_BLANK  = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam logic [3:0] SEG_BLANK_NIB = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  // Nibble to segments a..g; non-decimal codes (including the blank nibble) are dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return 7'h00;
    endcase
  endfunction

  // 10^n, used to derive the per-field saturation limit.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Serial double-dabble converter: one input bit per cycle after i_start.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int unsigned VAL_W        = 16,
  parameter int unsigned FIELD_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [VAL_W-1:0]            i_bin,
  output logic                        o_done_c,
  output logic [4*FIELD_DIGITS-1:0]   o_bcd
);

  localparam int unsigned BCD_W = 4 * FIELD_DIGITS;
  localparam int unsigned CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  logic [VAL_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < int'(FIELD_DIGITS); d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[VAL_W-1]};
      r_bin <= {r_bin[VAL_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(VAL_W - 1)) r_run <= 1'b0;
    end
  end

  assign o_done_c = r_run && (r_cnt == CNT_W'(VAL_W - 1));
  assign o_bcd    = r_bcd;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with shared sequential BCD conversion, blink, PWM dim and DP mask.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_FIELDS   = 2,
  parameter int unsigned FIELD_DIGITS = 4,
  parameter int unsigned VAL_W        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_tick_scan,
  input  logic                                 i_tick_blink,
  input  logic [NUM_FIELDS*VAL_W-1:0]          i_field_val,
  input  logic                                 i_load,
  output logic                                 o_busy,
  input  logic [NUM_FIELDS-1:0]                i_field_blink,
  input  logic [NUM_FIELDS*FIELD_DIGITS-1:0]   i_dp_mask,
  input  logic [2:0]                           i_dim_level,
  output logic [7:0]                           o_seg_data,
  output logic [NUM_FIELDS*FIELD_DIGITS-1:0]   o_seg_com
);

  localparam int unsigned NUM_DIGITS = NUM_FIELDS * FIELD_DIGITS;
  localparam int unsigned BCD_W      = 4 * FIELD_DIGITS;
  localparam int unsigned FIDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned SCAN_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MAX_VAL    = pow10(FIELD_DIGITS) - 1;

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_nxt;
  logic [NUM_FIELDS*VAL_W-1:0] r_hold;
  logic [FIDX_W-1:0]           r_fidx;
  logic [NUM_DIGITS*4-1:0]     r_stage;
  logic [NUM_DIGITS*4-1:0]     r_disp;
  logic                        r_busy;
  logic [VAL_W-1:0]            w_raw;
  logic [VAL_W-1:0]            w_clamped;
  logic                        w_start_c;
  logic                        w_done_c;
  logic [BCD_W-1:0]            w_bcd;
  logic [BCD_W-1:0]            w_blanked;
  logic                        w_lead;
  logic                        w_last_field;
  logic [SCAN_W-1:0]           r_scan;
  logic [2:0]                  r_pwm;
  logic                        r_blink;
  logic [3:0]                  w_nib;
  logic [NUM_DIGITS-1:0]       w_dig_blink;
  logic                        w_lit;
  logic [NUM_DIGITS-1:0]       r_com;
  logic [7:0]                  r_seg;

  bin2bcd_seq #(
    .VAL_W        (VAL_W),
    .FIELD_DIGITS (FIELD_DIGITS)
  ) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start_c),
    .i_bin    (w_clamped),
    .o_done_c (w_done_c),
    .o_bcd    (w_bcd)
  );

  // Select the field being converted and saturate it to the digit capacity.
  always_comb begin
    w_raw = '0;
    for (int f = 0; f < int'(NUM_FIELDS); f++) begin
      if (r_fidx == FIDX_W'(f)) w_raw = r_hold[f*VAL_W +: VAL_W];
    end
    w_clamped = (32'(w_raw) > MAX_VAL) ? VAL_W'(MAX_VAL) : w_raw;
  end

  // Leading-zero blanking from the top digit down; the ones digit always shows.
  always_comb begin
    w_blanked = w_bcd;
    w_lead    = 1'b1;
    for (int d = int'(FIELD_DIGITS) - 1; d >= 1; d--) begin
      if (w_lead && (w_bcd[d*4 +: 4] == 4'h0)) w_blanked[d*4 +: 4] = SEG_BLANK_NIB;
      else w_lead = 1'b0;
    end
  end

  assign w_last_field = (r_fidx == FIDX_W'(NUM_FIELDS - 1));
  assign w_start_c    = (r_state == ST_CLAMP);

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Conversion FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_load) w_state_nxt = ST_CLAMP;
      ST_CLAMP:  w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (w_done_c) w_state_nxt = ST_BLANK;
      ST_BLANK:  w_state_nxt = w_last_field ? ST_COMMIT : ST_CLAMP;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture, per-field staging and atomic commit into the display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_fidx  <= '0;
      r_stage <= '1;
      r_disp  <= '1;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if ((r_state == ST_IDLE) && i_load) begin
        r_hold <= i_field_val;
        r_fidx <= '0;
      end
      if (r_state == ST_BLANK) begin
        for (int f = 0; f < int'(NUM_FIELDS); f++) begin
          if (r_fidx == FIDX_W'(f)) r_stage[f*BCD_W +: BCD_W] <= w_blanked;
        end
        if (!w_last_field) r_fidx <= r_fidx + FIDX_W'(1);
      end
      if (r_state == ST_COMMIT) r_disp <= r_stage;
    end
  end

  // Digit scan index, PWM counter and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan  <= '0;
      r_pwm   <= '0;
      r_blink <= 1'b0;
    end else begin
      r_pwm <= r_pwm + 3'd1;
      if (i_tick_scan) begin
        if (r_scan == SCAN_W'(NUM_DIGITS - 1)) r_scan <= '0;
        else                                    r_scan <= r_scan + SCAN_W'(1);
      end
      if (i_tick_blink) r_blink <= ~r_blink;
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dig_blink
    assign w_dig_blink[g] = i_field_blink[g / FIELD_DIGITS];
  end

  // Nibble of the currently scanned digit.
  always_comb begin
    w_nib = SEG_BLANK_NIB;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_scan == SCAN_W'(i)) w_nib = r_disp[i*4 +: 4];
    end
  end

  assign w_lit = (r_pwm <= i_dim_level);

  // Registered segment and common drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_com <= '1;
      r_seg <= 8'h00;
    end else if (w_lit) begin
      r_com <= ~(NUM_DIGITS'(1) << r_scan);
      r_seg <= (r_blink && w_dig_blink[r_scan]) ? 8'h00
                                                : {i_dp_mask[r_scan], seg_encode(w_nib)};
    end else begin
      r_com <= '1;
      r_seg <= 8'h00;
    end
  end

  assign o_busy     = r_busy;
  assign o_seg_data = r_seg;
  assign o_seg_com  = r_com;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: arithmetic reference model plus directed literal checks.
module tb_seg_scan_display;

  localparam int NF       = 2;
  localparam int FD       = 4;
  localparam int VW       = 16;
  localparam int ND       = NF * FD;
  localparam int MAXV     = 9999;
  localparam int BUSY_LEN = NF * (VW + 2) + 1;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           tick_scan  = 1'b0;
  logic           tick_blink = 1'b0;
  logic           load       = 1'b0;
  logic [NF*VW-1:0] field_val = '0;
  logic [NF-1:0]  field_blink = '0;
  logic [ND-1:0]  dp_mask    = '0;
  logic [2:0]     dim_level  = 3'd7;
  logic           busy;
  logic [7:0]     seg_data;
  logic [ND-1:0]  seg_com;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  int m_pwm, m_scan, m_blink, m_cnt;
  int m_disp [ND];
  int m_pend [ND];
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_com;
  logic          exp_busy;

  logic [7:0] basic_exp [ND] = '{8'h7D, 8'h6D, 8'h00, 8'h00, 8'h66, 8'h4F, 8'h5B, 8'h06};
  logic [7:0] sat_exp   [ND] = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h6F, 8'h6F, 8'h6F};

  seg_scan_display #(.NUM_FIELDS(NF), .FIELD_DIGITS(FD), .VAL_W(VW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick_scan   (tick_scan),
    .i_tick_blink  (tick_blink),
    .i_field_val   (field_val),
    .i_load        (load),
    .o_busy        (busy),
    .i_field_blink (field_blink),
    .i_dp_mask     (dp_mask),
    .i_dim_level   (dim_level),
    .o_seg_data    (seg_data),
    .o_seg_com     (seg_com)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference model: digits as decimal ints (-1 = dark), conversion as a countdown.
  always @(posedge clk or posedge rst) begin
    int v, p, fld;
    bit lit;
    if (rst) begin
      m_pwm = 0; m_scan = 0; m_blink = 0; m_cnt = 0;
      for (int i = 0; i < ND; i++) m_disp[i] = -1;
      exp_seg = 8'h00; exp_com = '1; exp_busy = 1'b0;
    end else begin
      fld = m_scan / FD;
      lit = (m_pwm <= int'(dim_level));
      exp_com = lit ? ~(ND'(1) << m_scan) : '1;
      if (lit && !(m_blink == 1 && field_blink[fld]))
        exp_seg = {dp_mask[m_scan], glyph(m_disp[m_scan])};
      else
        exp_seg = 8'h00;
      m_pwm = (m_pwm + 1) % 8;
      if (tick_scan) m_scan = (m_scan + 1) % ND;
      if (tick_blink) m_blink = 1 - m_blink;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_disp = m_pend;
      end else if (load) begin
        for (int f = 0; f < NF; f++) begin
          v = int'(field_val[f*VW +: VW]);
          if (v > MAXV) v = MAXV;
          p = 1;
          for (int n = 0; n < FD; n++) begin
            m_pend[f*FD + n] = (n > 0 && v < p) ? -1 : (v / p) % 10;
            p = p * 10;
          end
        end
        m_cnt = BUSY_LEN;
      end
      exp_busy = (m_cnt > 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic compare_loop();
    while (!done) begin
      @(negedge clk);
      if (!rst && !done) begin
        chk("seg_model", 32'(seg_data), 32'(exp_seg));
        chk("com_model", 32'(seg_com), 32'(exp_com));
        chk("busy_model", 32'(busy), 32'(exp_busy));
      end
    end
  endtask

  // Move the scan to digit d and wait until the output register reflects it.
  task automatic show(input int d);
    int n;
    n = 0;
    while (m_scan != d && n < 16) begin
      tick_scan = 1'b1;
      step();
      tick_scan = 1'b0;
      n++;
    end
    chk("scan_reach", 32'(m_scan), 32'(d));
    step();
    @(negedge clk);
  endtask

  task automatic load_wait(input string nm);
    int n;
    load = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(nm, 32'(n), 32'(BUSY_LEN));
  endtask

  initial begin
    int n, lit;
    fork
      compare_loop();
    join_none

    repeat (3) step();
    rst = 1'b0;

    // Reset asserted in the middle of scanning.
    for (int i = 0; i < 12; i++) begin
      tick_scan = (i % 2 == 0);
      step();
    end
    tick_scan = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_com", 32'(seg_com), 32'h0000_00FF);
    chk("rst_seg", 32'(seg_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    step();
    rst = 1'b0;
    show(3);
    chk("dark_seg_d3", 32'(seg_data), 32'h0);
    chk("dark_com_d3", 32'(seg_com), 32'h0000_00F7);

    // Basic conversion 1234 / 56.
    field_val = {16'd1234, 16'd56};
    load_wait("busy_len_basic");
    for (int d = 0; d < ND; d++) begin
      show(d);
      chk($sformatf("basic_d%0d", d), 32'(seg_data), 32'(basic_exp[d]));
    end

    // Saturation and zero, then a load on the cycle busy falls.
    field_val = {16'd65535, 16'd0};
    load_wait("busy_len_sat");
    load_wait("busy_len_b2b");
    for (int d = 0; d < ND; d++) begin
      show(d);
      chk($sformatf("sat_d%0d", d), 32'(seg_data), 32'(sat_exp[d]));
    end

    // Second load during a conversion is dropped.
    field_val = {16'd4321, 16'd7};
    load = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        field_val = {16'd1, 16'd1};
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    chk("busy_len_drop", 32'(n), 32'(BUSY_LEN));
    show(0); chk("drop_d0", 32'(seg_data), 32'h07);
    show(1); chk("drop_d1", 32'(seg_data), 32'h00);
    show(4); chk("drop_d4", 32'(seg_data), 32'h06);
    show(7); chk("drop_d7", 32'(seg_data), 32'h66);

    // Reset during a conversion aborts it and blanks the display.
    field_val = {16'd9999, 16'd9999};
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    repeat (45) step();
    chk("abort_busy_later", 32'(busy), 32'h0);
    for (int d = 0; d < ND; d++) begin
      show(d);
      chk($sformatf("abort_d%0d", d), 32'(seg_data), 32'h0);
    end

    // Blink field 1.
    field_val = {16'd1234, 16'd56};
    load_wait("busy_len_blink");
    field_blink = 2'b10;
    tick_blink = 1'b1;
    step();
    tick_blink = 1'b0;
    show(4); chk("blink_d4_seg", 32'(seg_data), 32'h00);
             chk("blink_d4_com", 32'(seg_com), 32'h0000_00EF);
    show(5); chk("blink_d5_seg", 32'(seg_data), 32'h00);
    show(0); chk("blink_d0_seg", 32'(seg_data), 32'h7D);
    tick_blink = 1'b1;
    step();
    tick_blink = 1'b0;
    show(4); chk("unblink_d4_seg", 32'(seg_data), 32'h66);

    // Dimming and decimal point on digit 4.
    field_blink = 2'b00;
    dim_level = 3'd3;
    dp_mask = 8'h10;
    show(4);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (seg_com == 8'hEF) begin
        lit++;
        chk("dim_lit_seg", 32'(seg_data), 32'hE6);
      end else begin
        chk("dim_dark_com", 32'(seg_com), 32'h0000_00FF);
        chk("dim_dark_seg", 32'(seg_data), 32'h0);
      end
    end
    chk("dim_lit_count", 32'(lit), 32'd4);
    show(0);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (seg_com == 8'hFE) begin
        lit++;
        chk("dp_off_d0", 32'(seg_data), 32'h7D);
      end
    end
    chk("dim_lit_count_d0", 32'(lit), 32'd4);

    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
